// File: rtl/rdc_seq_pkg.sv
// Shared types and constants for the A->B reset-domain-crossing sequencer.
// State values are fixed so the optional debug port (RDC_SEQ_DBG_EN) exposes a stable encoding.
package rdc_seq_pkg;

    localparam int unsigned STATE_W   = 3;
    localparam int unsigned DBG_CNT_W = 8;

    typedef enum logic [STATE_W-1:0] {
        ST_POR   = 3'd0,
        ST_REL_B = 3'd1,
        ST_REL_A = 3'd2,
        ST_RUN   = 3'd3,
        ST_ISO   = 3'd4,
        ST_RST_A = 3'd5
    } state_t;

    // Width needed to hold the larger of the two hold-off counts.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
        return $clog2(((a > b) ? a : b) + 1);
    endfunction

endpackage

// File: rtl/rdc_seq_timer.sv
// Down-counter for the sequencer hold-off phases: load on state entry,
// count down to zero and stay there; zero flag is read by the FSM.
module rdc_seq_timer #(
    parameter int unsigned CNT_W = 3
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/rdc_reset_sequencer.sv
// Orders reset release/assertion of launch domain A and capture domain B with a crossing clamp.
// Define RDC_SEQ_DBG_EN to add o_state and a saturating completed-sequence counter o_seq_cnt.
module rdc_reset_sequencer
    import rdc_seq_pkg::*;
#(
    parameter int unsigned ISO_CYCLES    = 2,
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_req_rst_a,
    input  logic                 i_req_rst_b,
    output logic                 o_rst_a_n,
    output logic                 o_rst_b_n,
    output logic                 o_iso_en,
    output logic                 o_ready
`ifdef RDC_SEQ_DBG_EN
    ,
    output logic [STATE_W-1:0]   o_state,
    output logic [DBG_CNT_W-1:0] o_seq_cnt
`endif
);

    localparam int unsigned      CNT_W       = cnt_width(ISO_CYCLES, SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] ISO_LOAD    = CNT_W'(ISO_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    state_t           r_state;
    state_t           w_next;
    logic             w_load;
    logic [CNT_W-1:0] w_load_val;
    logic             w_cnt_zero;
    logic             r_rst_a_n;
    logic             r_rst_b_n;
    logic             r_iso_en;
    logic             r_ready;

    rdc_seq_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_zero     (w_cnt_zero)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_POR;
        end else begin
            r_state <= w_next;
        end
    end

    // RST_A ignores the request on its entry edge, giving the one-cycle minimum hold.
    always_comb begin
        w_next     = r_state;
        w_load     = 1'b0;
        w_load_val = '0;
        case (r_state)
            ST_POR: begin
                w_next = ST_REL_B;
            end
            ST_REL_B: begin
                w_next     = ST_REL_A;
                w_load     = 1'b1;
                w_load_val = SETTLE_LOAD;
            end
            ST_REL_A: begin
                if (w_cnt_zero) begin
                    w_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (i_req_rst_a) begin
                    w_next     = ST_ISO;
                    w_load     = 1'b1;
                    w_load_val = ISO_LOAD;
                end
            end
            ST_ISO: begin
                if (w_cnt_zero) begin
                    w_next = ST_RST_A;
                end
            end
            ST_RST_A: begin
                if (!i_req_rst_a) begin
                    w_next     = ST_REL_A;
                    w_load     = 1'b1;
                    w_load_val = SETTLE_LOAD;
                end
            end
            default: begin
                w_next = ST_POR;
            end
        endcase
    end

    // Outputs are decoded from the next state so they change on the entry edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rst_a_n <= 1'b0;
            r_rst_b_n <= 1'b0;
            r_iso_en  <= 1'b1;
            r_ready   <= 1'b0;
        end else begin
            r_rst_a_n <= (w_next == ST_REL_A) || (w_next == ST_RUN) || (w_next == ST_ISO);
            r_rst_b_n <= ~i_req_rst_b;
            r_iso_en  <= (w_next != ST_RUN);
            r_ready   <= (w_next == ST_RUN);
        end
    end

    assign o_rst_a_n = r_rst_a_n;
    assign o_rst_b_n = r_rst_b_n;
    assign o_iso_en  = r_iso_en;
    assign o_ready   = r_ready;

`ifdef RDC_SEQ_DBG_EN
    logic                 r_seq_pend;
    logic [DBG_CNT_W-1:0] r_seq_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_seq_pend <= 1'b0;
            r_seq_cnt  <= '0;
        end else if (w_next == ST_RST_A) begin
            r_seq_pend <= 1'b1;
        end else if ((r_state == ST_REL_A) && (w_next == ST_RUN)) begin
            r_seq_pend <= 1'b0;
            if (r_seq_pend && (r_seq_cnt != '1)) begin
                r_seq_cnt <= r_seq_cnt + 1'b1;
            end
        end
    end

    assign o_state   = r_state;
    assign o_seq_cnt = r_seq_cnt;
`endif

    a_clamp_covers_reset: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !r_rst_a_n |-> r_iso_en);
    a_clamp_before_reset: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        $fell(r_rst_a_n) |-> $past(r_iso_en, ISO_CYCLES));
    a_clamp_after_release: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        $fell(r_iso_en) |-> $past(r_rst_a_n, SETTLE_CYCLES));

endmodule

// File: tb/tb_rdc_reset_sequencer.sv
// Self-checking bench: directed timing scenarios plus random requests against a phase-level model.
// Instance u0 uses default timing, u1 uses ISO_CYCLES=3 / SETTLE_CYCLES=1.
module tb_rdc_reset_sequencer;

    localparam int PH_BOOT   = 0;
    localparam int PH_BUP    = 1;
    localparam int PH_SETTLE = 2;
    localparam int PH_RUN    = 3;
    localparam int PH_CLAMP  = 4;
    localparam int PH_AOFF   = 5;

    logic clk;
    logic rst_n;
    logic req_a;
    logic req_b;
    logic a0, b0, iso0, rdy0;
    logic a1, b1, iso1, rdy1;
    logic [1:0] w_a, w_b, w_iso, w_rdy;

    assign w_a   = {a1, a0};
    assign w_b   = {b1, b0};
    assign w_iso = {iso1, iso0};
    assign w_rdy = {rdy1, rdy0};

`ifdef RDC_SEQ_DBG_EN
    logic [2:0] st0, st1;
    logic [7:0] sc0, sc1;
`endif

    int n_vec;
    int n_err;

    int m_ph   [2];
    int m_left [2];
    int m_seq  [2];
    bit m_held [2];
    bit m_b    [2];

    rdc_reset_sequencer u0 (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req_rst_a (req_a),
        .i_req_rst_b (req_b),
        .o_rst_a_n   (a0),
        .o_rst_b_n   (b0),
        .o_iso_en    (iso0),
        .o_ready     (rdy0)
`ifdef RDC_SEQ_DBG_EN
        ,
        .o_state     (st0),
        .o_seq_cnt   (sc0)
`endif
    );

    rdc_reset_sequencer #(
        .ISO_CYCLES    (3),
        .SETTLE_CYCLES (1)
    ) u1 (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req_rst_a (req_a),
        .i_req_rst_b (req_b),
        .o_rst_a_n   (a1),
        .o_rst_b_n   (b1),
        .o_iso_en    (iso1),
        .o_ready     (rdy1)
`ifdef RDC_SEQ_DBG_EN
        ,
        .o_state     (st1),
        .o_seq_cnt   (sc1)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int iso_of(input int i);
        return (i == 0) ? 2 : 3;
    endfunction

    function automatic int set_of(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    // Expected {rst_a_n, rst_b_n, iso_en, ready} from the model phase.
    function automatic logic [3:0] exp_vec(input int i);
        logic a;
        logic rdy;
        a   = (m_ph[i] == PH_SETTLE) || (m_ph[i] == PH_RUN) || (m_ph[i] == PH_CLAMP);
        rdy = (m_ph[i] == PH_RUN);
        return {a, m_b[i], !rdy, rdy};
    endfunction

`ifdef RDC_SEQ_DBG_EN
    function automatic logic [7:0] dbg_cnt(input int i);
        return (i == 0) ? sc0 : sc1;
    endfunction

    function automatic logic [2:0] dbg_state(input int i);
        return (i == 0) ? st0 : st1;
    endfunction
`endif

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_ph[i]   = PH_BOOT;
            m_left[i] = 0;
            m_seq[i]  = 0;
            m_held[i] = 1'b0;
            m_b[i]    = 1'b0;
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            m_b[i] = ~req_b;
            case (m_ph[i])
                PH_BOOT: m_ph[i] = PH_BUP;
                PH_BUP: begin
                    m_ph[i]   = PH_SETTLE;
                    m_left[i] = set_of(i);
                end
                PH_SETTLE: begin
                    m_left[i]--;
                    if (m_left[i] == 0) begin
                        m_ph[i] = PH_RUN;
                        if (m_held[i] && m_seq[i] < 255) m_seq[i]++;
                        m_held[i] = 1'b0;
                    end
                end
                PH_RUN: begin
                    if (req_a) begin
                        m_ph[i]   = PH_CLAMP;
                        m_left[i] = iso_of(i);
                    end
                end
                PH_CLAMP: begin
                    m_left[i]--;
                    if (m_left[i] == 0) m_ph[i] = PH_AOFF;
                end
                PH_AOFF: begin
                    if (!req_a) begin
                        m_ph[i]   = PH_SETTLE;
                        m_left[i] = set_of(i);
                        m_held[i] = 1'b1;
                    end
                end
                default: m_ph[i] = PH_BOOT;
            endcase
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst_n) model_step();
        #1;
    endtask

    task automatic wait_ready0();
        int t;
        t = 0;
        while (w_rdy[0] !== 1'b1 && t < 40) begin
            cycle();
            t++;
        end
        n_vec++;
        if (w_rdy[0] !== 1'b1) begin
            $display("FAIL wait_ready timeout got ready=%b expected 1", w_rdy[0]);
            n_err++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_a = 1'b0;
        req_b = 1'b0;
        model_reset();
        #12;
        for (int i = 0; i < 2; i++) begin
            n_vec++;
            if ({w_a[i], w_b[i], w_iso[i], w_rdy[i]} !== 4'b0010) begin
                $display("FAIL reset_values inst%0d got a/b/iso/rdy=%b expected 0010", i,
                         {w_a[i], w_b[i], w_iso[i], w_rdy[i]});
                n_err++;
            end
`ifdef RDC_SEQ_DBG_EN
            n_vec++;
            if (dbg_cnt(i) !== 8'd0) begin
                $display("FAIL reset_seq_cnt inst%0d got %0d expected 0", i, dbg_cnt(i));
                n_err++;
            end
`endif
        end
    endtask

    task automatic test_powerup();
        logic [3:0] e0;
        logic [2:0] e1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            cycle();
            e0 = {(e >= 2) ? 1'b1 : 1'b0, 1'b1, (e < 6) ? 1'b1 : 1'b0, (e >= 6) ? 1'b1 : 1'b0};
            e1 = {(e >= 2) ? 1'b1 : 1'b0, (e < 3) ? 1'b1 : 1'b0, (e >= 3) ? 1'b1 : 1'b0};
            n_vec++;
            if ({a0, b0, iso0, rdy0} !== e0) begin
                $display("FAIL powerup inst0 edge%0d got a/b/iso/rdy=%b expected %b", e,
                         {a0, b0, iso0, rdy0}, e0);
                n_err++;
            end
            n_vec++;
            if ({a1, iso1, rdy1} !== e1) begin
                $display("FAIL powerup inst1 edge%0d got a/iso/rdy=%b expected %b", e,
                         {a1, iso1, rdy1}, e1);
                n_err++;
            end
        end
    endtask

    task automatic test_iso_pulse5();
        wait_ready0();
        for (int j = 0; j <= 10; j++) begin
            req_a = (j < 5);
            cycle();
            n_vec++;
            if (a0 !== ((j >= 2 && j <= 4) ? 1'b0 : 1'b1)) begin
                $display("FAIL pulse5_rst_a edge k+%0d got %b expected %b", j, a0,
                         (j >= 2 && j <= 4) ? 1'b0 : 1'b1);
                n_err++;
            end
            n_vec++;
            if ({iso0, rdy0} !== ((j <= 8) ? 2'b10 : 2'b01)) begin
                $display("FAIL pulse5_iso_rdy edge k+%0d got %b expected %b", j, {iso0, rdy0},
                         (j <= 8) ? 2'b10 : 2'b01);
                n_err++;
            end
        end
    endtask

    task automatic test_one_cycle();
        wait_ready0();
        for (int j = 0; j <= 8; j++) begin
            req_a = (j == 0);
            cycle();
            n_vec++;
            if (a0 !== ((j == 2) ? 1'b0 : 1'b1)) begin
                $display("FAIL pulse1_rst_a edge k+%0d got %b expected %b", j, a0,
                         (j == 2) ? 1'b0 : 1'b1);
                n_err++;
            end
            n_vec++;
            if (rdy0 !== ((j >= 7) ? 1'b1 : 1'b0)) begin
                $display("FAIL pulse1_ready edge k+%0d got %b expected %b", j, rdy0,
                         (j >= 7) ? 1'b1 : 1'b0);
                n_err++;
            end
        end
    endtask

    task automatic test_b_during_iso();
        int zeros;
        zeros = 0;
        wait_ready0();
        for (int j = 0; j <= 8; j++) begin
            req_a = (j == 0);
            req_b = (j >= 1 && j <= 3);
            cycle();
            if (b0 === 1'b0) zeros++;
            n_vec++;
            if (b0 !== ((j >= 1 && j <= 3) ? 1'b0 : 1'b1)) begin
                $display("FAIL breq_rst_b edge k+%0d got %b expected %b", j, b0,
                         (j >= 1 && j <= 3) ? 1'b0 : 1'b1);
                n_err++;
            end
            n_vec++;
            if ({a0, rdy0} !== {(j == 2) ? 1'b0 : 1'b1, (j >= 7) ? 1'b1 : 1'b0}) begin
                $display("FAIL breq_fsm edge k+%0d got a/rdy=%b expected %b", j, {a0, rdy0},
                         {(j == 2) ? 1'b0 : 1'b1, (j >= 7) ? 1'b1 : 1'b0});
                n_err++;
            end
        end
        n_vec++;
        if (zeros !== 3) begin
            $display("FAIL breq_low_cycles got %0d expected 3", zeros);
            n_err++;
        end
    endtask

    task automatic test_async_reset();
        wait_ready0();
        req_a = 1'b1;
        cycle();
        req_a = 1'b0;
        cycle();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            n_vec++;
            if ({w_a[i], w_b[i], w_iso[i], w_rdy[i]} !== 4'b0010) begin
                $display("FAIL async_reset inst%0d got a/b/iso/rdy=%b expected 0010", i,
                         {w_a[i], w_b[i], w_iso[i], w_rdy[i]});
                n_err++;
            end
        end
        for (int c = 0; c < 3; c++) begin
            cycle();
            n_vec++;
            if ({a0, b0, iso0, rdy0} !== 4'b0010) begin
                $display("FAIL reset_held cyc%0d got a/b/iso/rdy=%b expected 0010", c,
                         {a0, b0, iso0, rdy0});
                n_err++;
            end
        end
        test_powerup();
    endtask

    task automatic test_random();
        int iso_run     [2];
        int settle_left [2];
        bit prev_a      [2];
        rst_n = 1'b0;
        req_a = 1'b0;
        req_b = 1'b0;
        model_reset();
        #3;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            iso_run[i]     = 0;
            settle_left[i] = 0;
            prev_a[i]      = 1'b0;
        end
        for (int c = 0; c < 10000; c++) begin
            if ($urandom_range(0, 7) == 0) req_a = ~req_a;
            if ($urandom_range(0, 9) == 0) req_b = ~req_b;
            cycle();
            for (int i = 0; i < 2; i++) begin
                n_vec++;
                if ({w_a[i], w_b[i], w_iso[i], w_rdy[i]} !== exp_vec(i)) begin
                    $display("FAIL rand_outputs inst%0d cyc%0d got a/b/iso/rdy=%b expected %b",
                             i, c, {w_a[i], w_b[i], w_iso[i], w_rdy[i]}, exp_vec(i));
                    n_err++;
                end
                if (!w_a[i]) begin
                    n_vec++;
                    if (w_iso[i] !== 1'b1) begin
                        $display("FAIL inv_clamp inst%0d cyc%0d got iso=%b expected 1", i, c, w_iso[i]);
                        n_err++;
                    end
                end
                if (prev_a[i] && !w_a[i]) begin
                    n_vec++;
                    if (iso_run[i] < iso_of(i)) begin
                        $display("FAIL inv_iso_before inst%0d cyc%0d got %0d cycles expected >=%0d",
                                 i, c, iso_run[i], iso_of(i));
                        n_err++;
                    end
                end
                if (!prev_a[i] && w_a[i]) settle_left[i] = set_of(i);
                if (settle_left[i] > 0) begin
                    n_vec++;
                    if (w_iso[i] !== 1'b1) begin
                        $display("FAIL inv_settle inst%0d cyc%0d got iso=%b expected 1", i, c, w_iso[i]);
                        n_err++;
                    end
                    settle_left[i]--;
                end
                iso_run[i] = (w_iso[i] === 1'b1) ? iso_run[i] + 1 : 0;
                prev_a[i]  = w_a[i];
`ifdef RDC_SEQ_DBG_EN
                n_vec++;
                if (dbg_cnt(i) !== 8'(m_seq[i])) begin
                    $display("FAIL rand_seq_cnt inst%0d cyc%0d got %0d expected %0d", i, c,
                             dbg_cnt(i), m_seq[i]);
                    n_err++;
                end
                n_vec++;
                if ((dbg_state(i) == rdc_seq_pkg::ST_RUN) !== (m_ph[i] == PH_RUN)) begin
                    $display("FAIL rand_state inst%0d cyc%0d got state=%0d expected run=%0d", i, c,
                             dbg_state(i), (m_ph[i] == PH_RUN));
                    n_err++;
                end
`endif
            end
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_powerup();
        test_iso_pulse5();
        test_one_cycle();
        test_b_during_iso();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
